// File: rtl/canvas_scanout.sv
// Raster scan-out of the 50x50 paint canvas: reads the canvas RAM, overlays the
// cursor square and streams 12-bit pixels over valid/ready, plus a per-frame tick.
module canvas_scanout #(
  parameter int unsigned X_MAX     = 50,
  parameter int unsigned Y_MAX     = 50,
  parameter int unsigned V_BLANK   = 2,
  parameter int unsigned PAD_SIZE  = 8,
  parameter logic [11:0] PAD_RGB   = 12'd2,
  parameter logic [11:0] PAINT_RGB = 12'd1,
  parameter logic [11:0] BG_RGB    = 12'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  cursor_x,
  input  logic [9:0]  cursor_y,
  output logic        rd_en,
  output logic [11:0] rd_addr,
  input  logic        rd_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [11:0] pix_rgb,
  output logic [5:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic        pix_eol,
  output logic        pix_sof,
  output logic        refresh_tick
);

  localparam logic [10:0] X_LAST   = 11'(X_MAX - 1);
  localparam logic [10:0] Y_ACT    = 11'(Y_MAX);
  localparam logic [10:0] Y_LAST   = 11'(Y_MAX + V_BLANK - 1);
  localparam logic [10:0] PAD_SPAN = 11'(PAD_SIZE - 1);
  localparam logic [11:0] X_MUL    = 12'(X_MAX);

  logic [10:0] x_q, x_d, y_q, y_d;
  logic        s1_valid_q, s1_valid_d;
  logic [10:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [9:0]  cx_q, cx_d, cy_q, cy_d;
  logic        out_valid_q, out_valid_d;
  logic [11:0] out_rgb_q, out_rgb_d;
  logic [5:0]  out_x_q, out_x_d, out_y_q, out_y_d;
  logic        out_eol_q, out_eol_d;
  logic        out_sof_q, out_sof_d;

  logic        active, adv, step, tick, in_box;
  logic [10:0] cx_hi, cy_hi;
  logic [11:0] color;

  always_comb begin
    active = (y_q < Y_ACT);
    adv    = !out_valid_q || pix_ready;
    tick   = (x_q == '0) && (y_q == Y_ACT);
    // Blanking lines run free; only the active region is throttled by the sink.
    step   = active ? adv : 1'b1;

    x_d = x_q;
    y_d = y_q;
    if (step) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end

    cx_d = tick ? cursor_x : cx_q;
    cy_d = tick ? cursor_y : cy_q;

    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    if (adv) begin
      s1_valid_d = active;
      s1_x_d     = x_q;
      s1_y_d     = y_q;
    end

    // Box bounds kept at 11 bits so a cursor near the edge clips instead of wrapping.
    cx_hi  = {1'b0, cx_q} + PAD_SPAN;
    cy_hi  = {1'b0, cy_q} + PAD_SPAN;
    in_box = ({1'b0, cx_q} <= s1_x_q) && (s1_x_q <= cx_hi) &&
             ({1'b0, cy_q} <= s1_y_q) && (s1_y_q <= cy_hi);
    if (in_box)       color = PAD_RGB;
    else if (rd_data) color = PAINT_RGB;
    else              color = BG_RGB;

    out_valid_d = out_valid_q;
    out_rgb_d   = out_rgb_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_eol_d   = out_eol_q;
    out_sof_d   = out_sof_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      out_rgb_d   = s1_valid_q ? color : '0;
      out_x_d     = s1_x_q[5:0];
      out_y_d     = s1_y_q[5:0];
      out_eol_d   = s1_valid_q && (s1_x_q == X_LAST);
      out_sof_d   = s1_valid_q && (s1_x_q == '0) && (s1_y_q == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_eol_q   <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      out_valid_q <= out_valid_d;
      out_rgb_q   <= out_rgb_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_eol_q   <= out_eol_d;
      out_sof_q   <= out_sof_d;
    end
  end

  // Read strobe is gated by reset so every output is low while reset is held.
  assign rd_en        = active && adv && !reset;
  assign rd_addr      = ({1'b0, y_q} * X_MUL) + {1'b0, x_q};
  assign refresh_tick = tick;
  assign pix_valid    = out_valid_q;
  assign pix_rgb      = out_rgb_q;
  assign pix_x        = out_x_q;
  assign pix_y        = out_y_q;
  assign pix_eol      = out_eol_q;
  assign pix_sof      = out_sof_q;

endmodule

// File: tb/tb_canvas_scanout.sv
// Directed bench for canvas_scanout: canvas RAM model, beat monitor with a
// pixel reference, and per-frame checks against hand-computed counts.
module tb_canvas_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  cursor_x, cursor_y;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic        rd_data = 1'b0;
  logic        pix_valid, pix_ready;
  logic [11:0] pix_rgb;
  logic [5:0]  pix_x, pix_y;
  logic        pix_eol, pix_sof, refresh_tick;

  bit paint [0:2499];

  int vectors = 0, miscompares = 0;
  bit rand_ready = 0;

  int ex = 0, ey = 0, box_x = 0, box_y = 0;
  int f_beats = 0, f_pad = 0, f_paint = 0, f_eol = 0, f_err = 0, f_ticks = 0;
  int f_stalls = 0, f_minx = 99, f_miny = 99;
  int l_beats, l_pad, l_paint, l_eol, l_err, l_ticks, l_stalls, l_minx, l_miny;
  int frames_done = 0, cyc = 0, last_tick_cyc = -1, tick_period = 0;
  bit stalled_prev = 0;
  logic [11:0] h_rgb;
  logic [5:0]  h_x, h_y;

  canvas_scanout #(.X_MAX(50), .Y_MAX(50), .V_BLANK(2), .PAD_SIZE(8)) dut (
    .clk(clk), .reset(reset), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
    .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol), .pix_sof(pix_sof),
    .refresh_tick(refresh_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= paint[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_rgb(input int x, input int y);
    if (x >= box_x && x < box_x + 8 && y >= box_y && y < box_y + 8) return 2;
    if (paint[y*50 + x]) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      ex = 0; ey = 0; box_x = 0; box_y = 0;
      f_beats = 0; f_pad = 0; f_paint = 0; f_eol = 0; f_err = 0; f_ticks = 0;
      f_stalls = 0; f_minx = 99; f_miny = 99;
      last_tick_cyc = -1; stalled_prev = 0;
    end else begin
      if (refresh_tick) begin
        f_ticks++;
        if (last_tick_cyc >= 0) tick_period = cyc - last_tick_cyc;
        last_tick_cyc = cyc;
      end
      if (stalled_prev && (pix_valid !== 1'b1 || pix_rgb !== h_rgb ||
                           pix_x !== h_x || pix_y !== h_y)) f_err++;
      if (pix_valid && !pix_ready) begin
        f_stalls++;
        if (rd_en) f_err++;
      end
      stalled_prev = pix_valid && !pix_ready;
      h_rgb = pix_rgb; h_x = pix_x; h_y = pix_y;
      if (pix_valid && pix_ready) begin
        if (int'(pix_x) != ex || int'(pix_y) != ey) f_err++;
        if (int'(pix_rgb) != model_rgb(ex, ey)) f_err++;
        if (pix_sof !== (ex == 0 && ey == 0)) f_err++;
        if (pix_eol !== (ex == 49)) f_err++;
        f_beats++;
        if (pix_eol) f_eol++;
        if (pix_rgb == 12'd1) f_paint++;
        if (pix_rgb == 12'd2) begin
          f_pad++;
          if (int'(pix_x) < f_minx) f_minx = int'(pix_x);
          if (int'(pix_y) < f_miny) f_miny = int'(pix_y);
        end
        if (ex == 49 && ey == 49) begin
          l_beats = f_beats; l_pad = f_pad; l_paint = f_paint; l_eol = f_eol;
          l_err = f_err; l_ticks = f_ticks; l_stalls = f_stalls;
          l_minx = f_minx; l_miny = f_miny;
          f_beats = 0; f_pad = 0; f_paint = 0; f_eol = 0; f_err = 0; f_ticks = 0;
          f_stalls = 0; f_minx = 99; f_miny = 99;
          box_x = int'(cursor_x); box_y = int'(cursor_y);
          ex = 0; ey = 0;
          frames_done++;
        end else if (ex == 49) begin
          ex = 0; ey++;
        end else begin
          ex++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_frame(input string tag);
    int n0;
    bit done;
    n0 = frames_done;
    done = 0;
    for (int i = 0; i < 8000 && !done; i++) begin
      step();
      if (frames_done != n0) done = 1;
    end
    check({tag, "_frame_done"}, 32'(done), 32'd1);
  endtask

  task automatic first_beat(input string tag);
    step();
    check({tag, "_e1_valid"}, 32'(pix_valid), 32'd0);
    step();
    check({tag, "_e2_valid"}, 32'(pix_valid), 32'd1);
    check({tag, "_e2_xy"}, {pix_x, pix_y}, 32'd0);
    check({tag, "_e2_sof"}, 32'(pix_sof), 32'd1);
    check({tag, "_e2_rgb"}, 32'(pix_rgb), 32'd2);
  endtask

  task automatic frame_checks(input string tag, input int pad, input int minx,
                              input int miny, input int npaint);
    check({tag, "_err"}, l_err, 0);
    check({tag, "_beats"}, l_beats, 2500);
    check({tag, "_pad"}, l_pad, pad);
    check({tag, "_eol"}, l_eol, 50);
    check({tag, "_ticks"}, l_ticks, 1);
    check({tag, "_minx"}, l_minx, minx);
    check({tag, "_miny"}, l_miny, miny);
    check({tag, "_paint"}, l_paint, npaint);
  endtask

  initial begin
    bit hit;
    reset = 1'b1; cursor_x = 10'd10; cursor_y = 10'd20; pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    first_beat("rel0");

    repeat (100) step();
    #2 reset = 1'b1;
    #1;
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_rgb", 32'(pix_rgb), 32'd0);
    check("rst_xy", {pix_x, pix_y}, 32'd0);
    check("rst_flags", {pix_eol, pix_sof, refresh_tick, rd_en}, 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    first_beat("rel1");

    wait_frame("A");
    frame_checks("A", 64, 0, 0, 0);
    wait_frame("B");
    frame_checks("B", 64, 10, 20, 0);
    check("B_tick_period", tick_period, 2600);

    paint[5*50 + 5] = 1'b1;
    cursor_x = 10'd40; cursor_y = 10'd40;
    wait_frame("C");
    check("C_paint", l_paint, 1);
    wait_frame("D");
    frame_checks("D", 64, 40, 40, 1);

    cursor_x = 10'd0; cursor_y = 10'd0;
    wait_frame("E");
    wait_frame("F");
    frame_checks("F", 64, 0, 0, 0);
    paint[5*50 + 5] = 1'b0;

    cursor_x = 10'd10; cursor_y = 10'd20;
    rand_ready = 1;
    wait_frame("G");
    wait_frame("H");
    frame_checks("H", 64, 10, 20, 0);
    check("H_stalls_seen", 32'(l_stalls > 0), 32'd1);
    rand_ready = 0;

    hit = 0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      step();
      if (ex == 0 && ey == 25) hit = 1;
    end
    check("I_reach_0_25", 32'(hit), 32'd1);
    cursor_x = 10'd30;
    wait_frame("I");
    check("I_err", l_err, 0);
    check("I_minx", l_minx, 10);
    wait_frame("J");
    frame_checks("J", 64, 30, 20, 0);

    cursor_x = 10'd45; cursor_y = 10'd46;
    wait_frame("K");
    wait_frame("L");
    frame_checks("L", 20, 45, 46, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
